// File: rtl/serial_add_defs.sv
// Shared encodings for the bit-serial add/subtract unit: FSM states and op codes.
package serial_add_defs;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   typedef enum logic [1:0] {
      IDLE = S_IDLE,
      RUN  = S_RUN,
      DONE = S_DONE
   } state_t;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder composed of two half-adder cells.
module full_adder (
   input  logic x,
   input  logic y,
   input  logic ci,
   output logic s,
   output logic co
);

   logic s1;
   logic c1;
   logic c2;

   half_adder u_ha0 (.a(x),  .b(y),  .s(s1), .c(c1));
   half_adder u_ha1 (.a(s1), .b(ci), .s(s),  .c(c2));

   assign co = c1 | c2;

endmodule

// File: rtl/half_adder.sv
// Single-bit half adder cell.
module half_adder (
   input  logic a,
   input  logic b,
   output logic s,
   output logic c
);

   assign s = a ^ b;
   assign c = a & b;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial N-bit add/subtract: one full adder reused LSB-first over N cycles,
// sequenced by a start/done handshake.
module serial_add_ctrl
   import serial_add_defs::*;
#(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         op_sub,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] result,
   output logic         cout,
   output logic         overflow
);

   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST   = CW'(N - 1);
   localparam logic [CW-1:0] PENULT = CW'((N > 1) ? (N - 2) : 0);

   state_t        state;
   logic [N-1:0]  sa;
   logic [N-1:0]  sb;
   logic          carry;
   logic          c_msb_in;
   logic [CW-1:0] count;
   logic          sum;
   logic          co;
   logic [N-1:0]  result_shifted;

   full_adder u_fa (
      .x  (sa[0]),
      .y  (sb[0]),
      .ci (carry),
      .s  (sum),
      .co (co)
   );

   // New sum bit enters at the MSB so the LSB lands in bit 0 after N shifts.
   generate
      if (N == 1) begin : g_res1
         assign result_shifted = sum;
      end else begin : g_resn
         assign result_shifted = {sum, result[N-1:1]};
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         sa       <= '0;
         sb       <= '0;
         carry    <= 1'b0;
         c_msb_in <= 1'b0;
         count    <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         result   <= '0;
         cout     <= 1'b0;
         overflow <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               done <= 1'b0;
               if (start) begin
                  sa       <= a;
                  sb       <= (op_sub == OP_SUB) ? ~b : b;
                  carry    <= op_sub;
                  // Covers N=1, where the carry into the MSB is the initial carry.
                  c_msb_in <= op_sub;
                  count    <= '0;
                  busy     <= 1'b1;
                  state    <= RUN;
               end else begin
                  state <= IDLE;
               end
            end
            RUN: begin
               sa     <= sa >> 1;
               sb     <= sb >> 1;
               result <= result_shifted;
               carry  <= co;
               count  <= count + CW'(1);
               if (N > 1 && count == PENULT) begin
                  c_msb_in <= co;
               end
               if (count == LAST) begin
                  state    <= DONE;
                  busy     <= 1'b0;
                  done     <= 1'b1;
                  cout     <= co;
                  overflow <= c_msb_in ^ co;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed-vector bench for serial_add_ctrl at N=8 and N=1.
module tb_serial_add_ctrl;

   logic       clk = 1'b0;
   logic       rst;

   logic       start8, op8;
   logic [7:0] a8, b8;
   logic       busy8, done8, cout8, ovf8;
   logic [7:0] result8;

   logic       start1, op1;
   logic [0:0] a1, b1;
   logic       busy1, done1, cout1, ovf1;
   logic [0:0] result1;

   int vectors = 0;
   int fails   = 0;

   always #5 clk = ~clk;

   serial_add_ctrl #(.N(8)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .op_sub(op8), .a(a8), .b(b8),
      .busy(busy8), .done(done8), .result(result8), .cout(cout8), .overflow(ovf8)
   );

   serial_add_ctrl #(.N(1)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .op_sub(op1), .a(a1), .b(b1),
      .busy(busy1), .done(done1), .result(result1), .cout(cout1), .overflow(ovf1)
   );

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
      $fatal(1, "watchdog");
   end

   // Drive one accepted start on the 8-bit unit; returns at the negedge after acceptance.
   task automatic issue8(input logic [7:0] av, input logic [7:0] bv, input logic sub);
      @(negedge clk);
      start8 = 1'b1; a8 = av; b8 = bv; op8 = sub;
      @(negedge clk);
      start8 = 1'b0;
   endtask

   // Walk the 8 RUN cycles then check the DONE cycle; optionally pulse a stray start.
   task automatic run8(input string name, input logic [7:0] er, input logic ec,
                       input logic eo, input int inject_at);
      for (int cyc = 0; cyc < 8; cyc++) begin
         vectors++;
         if (busy8 !== 1'b1 || done8 !== 1'b0) begin
            fails++;
            $display("FAIL %s run cyc%0d: got busy=%b done=%b, want busy=1 done=0",
                     name, cyc, busy8, done8);
         end
         if (cyc == inject_at) begin
            start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55; op8 = 1'b0;
         end else begin
            start8 = 1'b0;
         end
         @(negedge clk);
      end
      vectors++;
      if (done8 !== 1'b1 || busy8 !== 1'b0 || result8 !== er || cout8 !== ec || ovf8 !== eo) begin
         fails++;
         $display("FAIL %s done: got done=%b busy=%b result=%h cout=%b ovf=%b, want 1 0 %h %b %b",
                  name, done8, busy8, result8, cout8, ovf8, er, ec, eo);
      end
      $display("%s: result=%h cout=%b ovf=%b", name, result8, cout8, ovf8);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      start8 = 1'b0; op8 = 1'b0; a8 = '0; b8 = '0;
      start1 = 1'b0; op1 = 1'b0; a1 = '0; b1 = '0;
      #12;
      vectors++;
      if ({busy8, done8, result8, cout8, ovf8} !== 12'h000) begin
         fails++;
         $display("FAIL reset8: got busy=%b done=%b result=%h cout=%b ovf=%b, want all 0",
                  busy8, done8, result8, cout8, ovf8);
      end
      vectors++;
      if ({busy1, done1, result1, cout1, ovf1} !== 5'b00000) begin
         fails++;
         $display("FAIL reset1: got busy=%b done=%b result=%b cout=%b ovf=%b, want all 0",
                  busy1, done1, result1, cout1, ovf1);
      end
      @(negedge clk);
      rst = 1'b0;
      $display("reset: outputs cleared");
   endtask

   task automatic test_add();
      issue8(8'h7F, 8'h01, 1'b0);
      run8("add_7F_01", 8'h80, 1'b0, 1'b1, -1);
      issue8(8'hFF, 8'h01, 1'b0);
      run8("add_FF_01", 8'h00, 1'b1, 1'b0, -1);
      @(negedge clk);
      vectors++;
      if (done8 !== 1'b0 || busy8 !== 1'b0 || result8 !== 8'h00 || cout8 !== 1'b1) begin
         fails++;
         $display("FAIL hold_idle: got done=%b busy=%b result=%h cout=%b, want 0 0 00 1",
                  done8, busy8, result8, cout8);
      end
   endtask

   task automatic test_sub();
      issue8(8'h05, 8'h07, 1'b1);
      run8("sub_05_07", 8'hFE, 1'b0, 1'b0, -1);
      issue8(8'h80, 8'h01, 1'b1);
      run8("sub_80_01", 8'h7F, 1'b1, 1'b1, -1);
      issue8(8'h00, 8'h00, 1'b1);
      run8("sub_00_00", 8'h00, 1'b1, 1'b0, -1);
   endtask

   task automatic test_back_to_back();
      issue8(8'h10, 8'h20, 1'b0);
      run8("ignore_start", 8'h30, 1'b0, 1'b0, 2);
      start8 = 1'b1; a8 = 8'h03; b8 = 8'h04; op8 = 1'b0;
      @(negedge clk);
      start8 = 1'b0;
      run8("back_to_back", 8'h07, 1'b0, 1'b0, -1);
   endtask

   task automatic test_async_reset();
      issue8(8'h80, 8'h01, 1'b1);
      run8("pre_reset", 8'h7F, 1'b1, 1'b1, -1);
      issue8(8'h55, 8'h00, 1'b0);
      repeat (3) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      vectors++;
      if ({busy8, done8, result8, cout8, ovf8} !== 12'h000) begin
         fails++;
         $display("FAIL async_reset: got busy=%b done=%b result=%h cout=%b ovf=%b, want all 0",
                  busy8, done8, result8, cout8, ovf8);
      end
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         vectors++;
         if (done8 !== 1'b0 || busy8 !== 1'b0) begin
            fails++;
            $display("FAIL post_reset cyc%0d: got done=%b busy=%b, want 0 0", i, done8, busy8);
         end
      end
      $display("async_reset: outputs cleared, no done pulse");
      issue8(8'h12, 8'h34, 1'b0);
      run8("after_reset", 8'h46, 1'b0, 1'b0, -1);
   endtask

   task automatic test_n1();
      @(negedge clk);
      start1 = 1'b1; a1 = 1'b1; b1 = 1'b1; op1 = 1'b0;
      @(negedge clk);
      start1 = 1'b0;
      vectors++;
      if (busy1 !== 1'b1 || done1 !== 1'b0) begin
         fails++;
         $display("FAIL n1_add run: got busy=%b done=%b, want 1 0", busy1, done1);
      end
      @(negedge clk);
      vectors++;
      if (done1 !== 1'b1 || busy1 !== 1'b0 || result1 !== 1'b0 || cout1 !== 1'b1 || ovf1 !== 1'b1) begin
         fails++;
         $display("FAIL n1_add done: got done=%b busy=%b result=%b cout=%b ovf=%b, want 1 0 0 1 1",
                  done1, busy1, result1, cout1, ovf1);
      end
      $display("n1_add_1_1: result=%b cout=%b ovf=%b", result1, cout1, ovf1);
      @(negedge clk);
      start1 = 1'b1; a1 = 1'b0; b1 = 1'b1; op1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      @(negedge clk);
      vectors++;
      if (done1 !== 1'b1 || result1 !== 1'b1 || cout1 !== 1'b0 || ovf1 !== 1'b1) begin
         fails++;
         $display("FAIL n1_sub done: got done=%b result=%b cout=%b ovf=%b, want 1 1 0 1",
                  done1, result1, cout1, ovf1);
      end
      $display("n1_sub_0_1: result=%b cout=%b ovf=%b", result1, cout1, ovf1);
   endtask

   initial begin
      test_reset();
      test_add();
      test_sub();
      test_back_to_back();
      test_async_reset();
      test_n1();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Bit-serial add/subtract unit for the ALU lab datapath.
- One shared full_adder instance is time-multiplexed across N cycles: LSB first, with a registered carry between bits.
- A start/done handshake sequences the operation, so N-bit arithmetic costs one adder cell instead of N.
- Sits beside the ripple ALU as the area-minimal arithmetic path.

Parameters:
- N, 8, operand/result width in bits (legal range 1..64).

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled on the rising clk edge.
- op_sub  input  1  0 = A+B, 1 = A-B; sampled with start.
- a  input  N  operand A; sampled with start.
- b  input  N  operand B; sampled with start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse: result, cout and overflow are valid.
- result  output  N  sum/difference; held until the next accepted start.
- cout  output  1  final carry out. For subtract, 1 = no borrow.
- overflow  output  1  signed overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Reset (async, rst=1): state=IDLE, busy=0, done=0, result=0, cout=0, overflow=0; all internal shift registers, carry register and bit counter cleared.
- States: IDLE, RUN, DONE.
- Start acceptance: start=1 at a rising edge in IDLE or DONE is accepted.
  - Latch a into shift register SA.
  - Latch b XOR {N{op_sub}} into shift register SB.
  - Carry register C <= op_sub; counter <= 0; state <= RUN.
- start in RUN is ignored; the operands must not disturb the operation in progress.
- RUN, each cycle:
  - The full_adder sees X=SA[0], Y=SB[0], ci=C.
  - On the edge: SA and SB shift right; sum shifts into result register MSB (right shift); C <= co; counter++.
  - On the edge where counter==N-2, also record C_msb_in <= co (carry into MSB). For N=1, C_msb_in = initial carry (op_sub).
  - On the edge processing bit N-1 (counter==N-1): state <= DONE, cout <= co, overflow <= C_msb_in XOR co.
- Latency: start accepted at edge t0.
  - busy=1 during cycles [t0, t0+N).
  - done=1 for exactly the cycle [t0+N, t0+N+1).
  - Start-to-done = N cycles.
- DONE: done=1, busy=0.
  - Next edge -> IDLE, unless start=1, which gives a back-to-back accept -> RUN.
  - done is still 1 in that DONE cycle either way.
- Output update timing:
  - The result register shifts during RUN, so result is only valid while done=1 and afterwards until the next accept.
  - Intermediate values are visible on result while busy=1; consumers must ignore them.
  - cout and overflow change only on the final RUN edge.
  - result, cout and overflow hold through IDLE indefinitely.
- Reset mid-operation: async clear to IDLE. No done pulse; the partial result is discarded (result=0).
- Width rules:
  - Arithmetic is modulo 2^N.
  - Counter width is clog2(N) but at least 1.
  - N=1 is legal: RUN lasts one cycle.
- Simultaneous events: rst dominates start. start together with an in-flight RUN is dropped; it is not queued.

Decomposition:
- Shared include/package (serial_add_defs): state encoding localparams S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2; op encoding OP_ADD=1'b0, OP_SUB=1'b1.
- Sub-module: exactly one instance of the existing full_adder (itself built from two half_adder cells); there is no behavioural "+".
- Everything else (FSM, shift registers, carry register, counter, flags) is flat in serial_add_ctrl.

Test Plan:
- N=8, add 0x7F+0x01 -> after 8 cycles done pulse with result=0x80, cout=0, overflow=1; busy high exactly 8 cycles.
- N=8, add 0xFF+0x01 -> result=0x00, cout=1, overflow=0. Then sub 0x05-0x07 -> result=0xFE, cout=0, overflow=0.
- N=8, sub 0x80-0x01 -> result=0x7F, cout=1, overflow=1. Then sub 0x00-0x00 -> result=0x00, cout=1, overflow=0.
- N=8, start 0x10+0x20, then pulse start with 0xAA+0x55 at cycle 3 of RUN -> ignored; done at cycle 8 with result=0x30. Back-to-back start held high in the DONE cycle -> second op accepted, done again 8 cycles later.
- N=8, assert rst asynchronously (mid-cycle) at RUN cycle 4 -> busy, done, result, cout and overflow go to 0 immediately without waiting for a clock edge; no done pulse follows. A new start after release gives a correct result.
- N=1, add 1+1 -> done after 1 cycle, result=0, cout=1, overflow=1. Sub 0-1 -> result=1, cout=0, overflow=1.
